port_irq_requester: RTL

- Peripheral-side requester for the CPU interrupt handler.
- Watches the four 8-bit input ports for value changes and latches per-port pending flags.
- Raises one port interrupt request at a time, with the port index and a captured data snapshot.
- Holds each request until the handler acknowledges it, then waits for the handler's "finished" strobe before issuing the next.

---
 rtl/port_irq_requester_pkg.sv | 21 ++
 rtl/port_irq_requester_port_change_detect.sv | 27 ++
 rtl/port_irq_requester.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/port_irq_requester_pkg.sv
// Shared types and constants for the port interrupt requester.
package port_irq_requester_pkg;

    localparam int unsigned NPORTS = 4;
    localparam int unsigned ID_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Fixed priority: lowest set index wins.
    function automatic logic [ID_W-1:0] prio_sel(input logic [NPORTS-1:0] v);
        prio_sel = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (v[i]) prio_sel = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/port_irq_requester_port_change_detect.sv
// Per-port change detector: previous-value register with arming so that the
// first cycle after reset release never reports a change.
module port_change_detect #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    output logic              chg
);

    logic [DATA_W-1:0] prev_q;
    logic              armed_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= value;
            armed_q <= 1'b1;
        end
    end

    assign chg = armed_q && (value != prev_q);

endmodule

// File: rtl/port_irq_requester.sv
// Port interrupt requester: flags port changes, issues one request at a time.
// Optional request timeout enabled by defining PORT_IRQ_TIMEOUT_EN.
module port_irq_requester
    import port_irq_requester_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_p0,
    input  logic [DATA_W-1:0] in_p1,
    input  logic [DATA_W-1:0] in_p2,
    input  logic [DATA_W-1:0] in_p3,
    input  logic              mask_we,
    input  logic [3:0]        mask_data,
    input  logic              irq_ack,
    input  logic              irq_done,
    output logic              irq_req,
    output logic [ID_W-1:0]   irq_id,
    output logic [DATA_W-1:0] irq_data,
    output logic [3:0]        pending,
`ifdef PORT_IRQ_TIMEOUT_EN
    output logic              irq_timeout,
`endif
    output logic              busy
);

    // The wait counter is 8 bits wide.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..256");
    end

    logic [DATA_W-1:0] port_val [NPORTS];
    logic [NPORTS-1:0] chg;

    assign port_val[0] = in_p0;
    assign port_val[1] = in_p1;
    assign port_val[2] = in_p2;
    assign port_val[3] = in_p3;

    for (genvar n = 0; n < NPORTS; n++) begin : g_port
        port_change_detect #(
            .DATA_W (DATA_W)
        ) u_detect (
            .clk   (clk),
            .reset (reset),
            .value (port_val[n]),
            .chg   (chg[n])
        );
    end

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NPORTS-1:0] pending_q, pending_d;
    logic [NPORTS-1:0] mask_q, mask_d;
    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] clr;
    logic [ID_W-1:0]   sel;

`ifdef PORT_IRQ_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif

    assign eligible = pending_q & mask_q;
    assign sel      = prio_sel(eligible);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        data_d  = data_q;
        mask_d  = mask_we ? mask_data : mask_q;
        clr     = '0;
`ifdef PORT_IRQ_TIMEOUT_EN
        cnt_d     = (state_q == ST_REQ) ? cnt_q + 8'd1 : 8'd0;
        timeout_d = mask_we ? 1'b0 : timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    id_d    = sel;
                    data_d  = port_val[sel];
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    req_d       = 1'b0;
                    clr[id_q]   = 1'b1;
                    state_d     = ST_SERVICE;
                end
`ifdef PORT_IRQ_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    // Pending stays set so the port is requested again.
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
`endif
            end
            ST_SERVICE: begin
                if (irq_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A change arriving with the ack re-sets the bit being cleared.
        pending_d = (pending_q & ~clr) | (chg & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            id_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
`ifdef PORT_IRQ_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            id_q      <= id_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
`ifdef PORT_IRQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign irq_req  = req_q;
    assign irq_id   = id_q;
    assign irq_data = data_q;
    assign pending  = pending_q;
    assign busy     = (state_q != ST_IDLE);
`ifdef PORT_IRQ_TIMEOUT_EN
    assign irq_timeout = timeout_q;
`endif

endmodule
